read_fill_data: RTL and testbench

- Read-side data path of the cache: returns the addressed 32-bit word to the system on a read hit, and assembles a 128-bit line from four 32-bit memory beats on a read miss.
- On a miss it forwards the requested word as soon as its beat arrives (early restart), then presents the complete line for the cache array write.
- Sits between the cache controller FSM, the data array read port and the memory read channel.
- Counterpart of the write-merge path.

---
 rtl/read_fill_data.sv | 126 ++++++++++++
 tb/tb_read_fill_data.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/read_fill_data.sv
// rtl/read_fill_data.sv - cache read data path: hit word select and miss line fill with early restart
// Optional build macro: CRITICAL_WORD_FIRST_EN (memory returns beats wrapping from the requested word)
module read_fill_data #(
   parameter int TIMEOUT = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hit_req,
   input  logic         fill_req,
   input  logic [1:0]   offset,
   input  logic [127:0] c_data,
   input  logic         mem_rvalid,
   input  logic [31:0]  mem_rdata,
   output logic [31:0]  sys_rdata,
   output logic         sys_ack,
   output logic [127:0] fill_data,
   output logic         fill_we,
   output logic         fill_err,
   output logic         busy
);

   // Idle counter only ever holds 0..TIMEOUT-1, so log2(TIMEOUT) bits are enough.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   logic [1:0]     beat_q;
   logic [1:0]     off_q;
   logic [TW-1:0]  to_q;
   logic [31:0]    sys_rdata_q;
   logic           sys_ack_q;
   logic [127:0]   fill_data_q;
   logic           fill_we_q;
   logic           fill_err_q;
   logic           busy_q;
   logic [1:0]     beat_idx;

   // Line slot written by the current beat; the requested word is the one whose slot equals the latched offset.
`ifdef CRITICAL_WORD_FIRST_EN
   assign beat_idx = off_q + beat_q;
`else
   assign beat_idx = beat_q;
`endif

   // Control FSM with all outputs registered; pulse outputs default low every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_q      <= 2'd0;
         off_q       <= 2'd0;
         to_q        <= '0;
         sys_rdata_q <= 32'd0;
         sys_ack_q   <= 1'b0;
         fill_data_q <= 128'd0;
         fill_we_q   <= 1'b0;
         fill_err_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sys_ack_q  <= 1'b0;
         fill_we_q  <= 1'b0;
         fill_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A hit wins over a simultaneous fill request; the fill is dropped.
               if (hit_req) begin
                  sys_rdata_q <= c_data[{offset, 5'b00000} +: 32];
                  sys_ack_q   <= 1'b1;
               end else if (fill_req) begin
                  off_q   <= offset;
                  beat_q  <= 2'd0;
                  to_q    <= '0;
                  state_q <= FILL;
                  busy_q  <= 1'b1;
               end
            end
            FILL: begin
               if (mem_rvalid) begin
                  fill_data_q[{beat_idx, 5'b00000} +: 32] <= mem_rdata;
                  beat_q <= beat_q + 2'd1;
                  to_q   <= '0;
                  // Early restart: forward the requested word straight from the beat.
                  if (beat_idx == off_q) begin
                     sys_rdata_q <= mem_rdata;
                     sys_ack_q   <= 1'b1;
                  end
                  if (beat_q == 2'd3) begin
                     state_q   <= DONE;
                     fill_we_q <= 1'b1;
                  end
               end else if (TIMEOUT != 0) begin
                  if (to_q == TO_LAST) begin
                     fill_err_q <= 1'b1;
                     state_q    <= IDLE;
                     busy_q     <= 1'b0;
                  end else begin
                     to_q <= to_q + TW'(1);
                  end
               end
            end
            DONE: begin
               // fill_we was raised on entry; this is the single cycle it is visible.
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sys_rdata = sys_rdata_q;
   assign sys_ack   = sys_ack_q;
   assign fill_data = fill_data_q;
   assign fill_we   = fill_we_q;
   assign fill_err  = fill_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_read_fill_data.sv
// tb/tb_read_fill_data.sv - directed self-checking bench for read_fill_data
module tb_read_fill_data;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         hit_req;
   logic         fill_req;
   logic [1:0]   offset;
   logic [127:0] c_data;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic [31:0]  sys_rdata;
   logic         sys_ack;
   logic [127:0] fill_data;
   logic         fill_we;
   logic         fill_err;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;

   read_fill_data #(.TIMEOUT(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hit_req    (hit_req),
      .fill_req   (fill_req),
      .offset     (offset),
      .c_data     (c_data),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .sys_rdata  (sys_rdata),
      .sys_ack    (sys_ack),
      .fill_data  (fill_data),
      .fill_we    (fill_we),
      .fill_err   (fill_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      hit_req    = 1'b0;
      fill_req   = 1'b0;
      offset     = 2'd0;
      c_data     = 128'h44444444_33333333_22222222_11111111;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      tick();
      tick();
      chk("rst_sys_rdata", 128'(sys_rdata), 128'd0);
      chk("rst_sys_ack",   128'(sys_ack),   128'd0);
      chk("rst_fill_data", fill_data,       128'd0);
      chk("rst_fill_we",   128'(fill_we),   128'd0);
      chk("rst_fill_err",  128'(fill_err),  128'd0);
      chk("rst_busy",      128'(busy),      128'd0);
      rst_n = 1'b1;
      tick();

      // Hit, offset 2
      offset = 2'd2; hit_req = 1'b1;
      tick();
      hit_req = 1'b0;
      chk("hit2_ack",   128'(sys_ack),   128'd1);
      chk("hit2_data",  128'(sys_rdata), 128'h33333333);
      chk("hit2_busy",  128'(busy),      128'd0);
      tick();
      chk("hit2_ack_pulse", 128'(sys_ack), 128'd0);

      // Hit, offset 3
      offset = 2'd3; hit_req = 1'b1;
      tick();
      hit_req = 1'b0;
      chk("hit3_data", 128'(sys_rdata), 128'h44444444);

`ifndef CRITICAL_WORD_FIRST_EN
      // In-order fill, offset 1, back-to-back beats
      offset = 2'd1; fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      chk("fo_busy", 128'(busy), 128'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'hA0;
      tick();
      chk("fo_b1_ack", 128'(sys_ack), 128'd0);
      mem_rdata = 32'hA1;
      tick();
      chk("fo_b2_ack",  128'(sys_ack),   128'd1);
      chk("fo_b2_data", 128'(sys_rdata), 128'hA1);
      mem_rdata = 32'hA2;
      tick();
      chk("fo_b3_ack", 128'(sys_ack), 128'd0);
      chk("fo_b3_we",  128'(fill_we), 128'd0);
      mem_rdata = 32'hA3;
      tick();
      mem_rvalid = 1'b0;
      chk("fo_we",   128'(fill_we), 128'd1);
      chk("fo_line", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
      chk("fo_ack0", 128'(sys_ack), 128'd0);
      chk("fo_busy_done", 128'(busy), 128'd1);
      tick();
      chk("fo_we_pulse", 128'(fill_we), 128'd0);
      chk("fo_idle",     128'(busy),    128'd0);

      // Beats in IDLE are ignored and a hit leaves the line alone
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
      tick();
      mem_rvalid = 1'b0;
      chk("idle_beat_busy", 128'(busy), 128'd0);
      chk("idle_beat_line", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
      offset = 2'd0; hit_req = 1'b1;
      tick();
      hit_req = 1'b0;
      chk("hit0_data", 128'(sys_rdata), 128'h11111111);
      chk("hit_keeps_line", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);

      // Gapped fill, offset 3, two idle cycles between beats; hits ignored while busy
      offset = 2'd3; fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            hit_req = (i == 1);
            tick();
            hit_req = 1'b0;
            chk("gap_ack_a", 128'(sys_ack), 128'd0);
            tick();
            chk("gap_ack_b", 128'(sys_ack), 128'd0);
         end
         mem_rvalid = 1'b1; mem_rdata = 32'hC0 + 32'(i);
         tick();
         mem_rvalid = 1'b0;
         if (i < 3) begin
            chk("gap_beat_ack", 128'(sys_ack), 128'd0);
            chk("gap_beat_we",  128'(fill_we), 128'd0);
         end
      end
      chk("gap_ack",  128'(sys_ack),   128'd1);
      chk("gap_data", 128'(sys_rdata), 128'hC3);
      chk("gap_we",   128'(fill_we),   128'd1);
      chk("gap_line", fill_data, 128'h000000C3_000000C2_000000C1_000000C0);
      tick();
      chk("gap_idle", 128'(busy), 128'd0);
`else
      // Critical word first, offset 2
      offset = 2'd2; fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hB0;
      tick();
      chk("cwf_ack",  128'(sys_ack),   128'd1);
      chk("cwf_data", 128'(sys_rdata), 128'hB0);
      mem_rdata = 32'hB1;
      tick();
      chk("cwf_ack_once", 128'(sys_ack), 128'd0);
      mem_rdata = 32'hB2;
      tick();
      mem_rdata = 32'hB3;
      tick();
      mem_rvalid = 1'b0;
      chk("cwf_we",   128'(fill_we), 128'd1);
      chk("cwf_line", fill_data, 128'h000000B1_000000B0_000000B3_000000B2);
      tick();
      chk("cwf_idle", 128'(busy), 128'd0);
`endif

      // Timeout: one beat then silence
      offset = 2'd0; fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hD0;
      tick();
      mem_rvalid = 1'b0;
      chk("to_ack",  128'(sys_ack),   128'd1);
      chk("to_data", 128'(sys_rdata), 128'hD0);
      for (int i = 0; i < 7; i++) tick();
      chk("to_err_early", 128'(fill_err), 128'd0);
      chk("to_busy_early", 128'(busy), 128'd1);
      tick();
      chk("to_err",  128'(fill_err), 128'd1);
      chk("to_busy", 128'(busy),     128'd0);
      chk("to_we",   128'(fill_we),  128'd0);
      tick();
      chk("to_err_pulse", 128'(fill_err), 128'd0);
      offset = 2'd1; hit_req = 1'b1;
      tick();
      hit_req = 1'b0;
      chk("to_hit_ack",  128'(sys_ack),   128'd1);
      chk("to_hit_data", 128'(sys_rdata), 128'h22222222);

      // Reset after two beats of a fill
      offset = 2'd3; fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hE0;
      tick();
      mem_rdata = 32'hE1;
      tick();
      mem_rvalid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("mr_sys_rdata", 128'(sys_rdata), 128'd0);
      chk("mr_fill_data", fill_data,       128'd0);
      chk("mr_busy",      128'(busy),      128'd0);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hE2;
      tick();
      mem_rdata = 32'hE3;
      tick();
      mem_rvalid = 1'b0;
      chk("mr_ack",  128'(sys_ack),  128'd0);
      chk("mr_we",   128'(fill_we),  128'd0);
      chk("mr_line", fill_data,      128'd0);
      tick();
      chk("mr_we_late", 128'(fill_we), 128'd0);

      // Hit and fill together: hit served, fill dropped
      offset = 2'd0; hit_req = 1'b1; fill_req = 1'b1;
      tick();
      hit_req = 1'b0; fill_req = 1'b0;
      chk("both_ack",  128'(sys_ack),   128'd1);
      chk("both_data", 128'(sys_rdata), 128'h11111111);
      chk("both_busy", 128'(busy),      128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
